bcd_conv_arbiter: RTL

BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

---
 rtl/bcd_conv_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/bcd_conv_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bcd_conv_arbiter                                                 |
// | Brief   : Four-requester arbiter for one shared binary-to-BCD converter,   |
// |           with round-robin grant, conversion timeout and result capture.   |
// |           Define BCD_ARB_FIXED_PRIO_EN for fixed lowest-index priority.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module bcd_conv_arbiter #(
  parameter int TIMEOUT_CYCLES = 100
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [127:0] value,
  output logic [3:0]   ack,
  output logic         err,
  output logic [31:0]  bcd_out,
  output logic [1:0]   grant_id,
  output logic         busy,
  output logic         dd_trigger,
  output logic [31:0]  dd_in,
  input  logic         dd_idle,
  input  logic [31:0]  dd_bcd
);

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [8:0] c_tmo = 9'(TIMEOUT_CYCLES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_grant;
  logic [31:0] r_dd_in;
  logic [31:0] r_bcd;
  logic [7:0]  r_tcnt;
  logic        r_timeout;
  logic [1:0]  w_win;
  logic        w_any;
  logic        w_tmo;

  assign w_any = |req;
  assign w_tmo = ({1'b0, r_tcnt} >= c_tmo);

`ifdef BCD_ARB_FIXED_PRIO_EN
  always_comb begin
    w_win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) w_win = 2'(i);
    end
  end
`else
  logic [1:0] r_last;
  logic [7:0] w_req2;
  logic [2:0] w_base;
  logic [3:0] w_rot;

  // Rotate so bit 0 is the requester right after the last one served.
  assign w_req2 = {req, req};
  assign w_base = {1'b0, r_last} + 3'd1;
  assign w_rot  = w_req2[w_base +: 4];

  always_comb begin
    w_win = 2'd0;
    for (int j = 3; j >= 0; j--) begin
      if (w_rot[j]) w_win = r_last + 2'd1 + 2'(j);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= 2'd3;
    end else if (r_state == ST_DONE) begin
      r_last <= r_grant;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARB: begin
        if (w_any && dd_idle) w_state_nxt = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        if (w_tmo)         w_state_nxt = ST_DONE;
        else if (!dd_idle) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (w_tmo || dd_idle) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_ARB;
      end
      default: begin
        w_state_nxt = ST_ARB;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_ARB;
      r_grant   <= 2'd0;
      r_dd_in   <= 32'd0;
      r_bcd     <= 32'd0;
      r_tcnt    <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_ARB: begin
          if (w_any && dd_idle) begin
            r_grant   <= w_win;
            r_dd_in   <= value[{w_win, 5'd0} +: 32];
            r_tcnt    <= 8'd0;
            r_timeout <= 1'b0;
          end
        end
        ST_LAUNCH, ST_BUSY: begin
          if (r_tcnt != 8'hFF) r_tcnt <= r_tcnt + 8'd1;
          // Timeout wins over a completion arriving in the same cycle.
          if (w_tmo) begin
            r_timeout <= 1'b1;
            r_bcd     <= 32'hFFFF_FFFF;
          end else if (r_state == ST_BUSY && dd_idle) begin
            r_bcd <= dd_bcd;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ack        = (r_state == ST_DONE) ? (4'b0001 << r_grant) : 4'b0000;
  assign err        = (r_state == ST_DONE) && r_timeout;
  assign busy       = (r_state != ST_ARB);
  assign dd_trigger = (r_state == ST_LAUNCH);
  assign dd_in      = r_dd_in;
  assign bcd_out    = r_bcd;
  assign grant_id   = r_grant;

endmodule
`default_nettype wire
